// File: rtl/adder_pkg.sv
// Shared types and elaboration-time helpers for the chunked serial adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) r++;
      return r;
   endfunction

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-chunk configuration still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; c_msb is the carry into the top bit,
// which the top uses for signed overflow.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      logic w_s1;
      logic w_c1;
      logic w_c2;

      half_adder u_ha0 (.a(a[i]), .b(b[i]),   .s(w_s1), .c(w_c1));
      half_adder u_ha1 (.a(w_s1), .b(w_c[i]), .s(s[i]), .c(w_c2));

      assign w_c[i+1] = w_c1 | w_c2;
   end

   assign co    = w_c[CHUNK];
   assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder, the leaf cell of the chunk ripple chain.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LSB chunk first.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module chunked_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [CHUNK-1:0] w_s;
   logic             w_co;
   logic             w_c_msb;
   logic [WIDTH-1:0] w_sum_next;
   logic             w_last;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (r_a[CHUNK-1:0]),
      .b     (r_b[CHUNK-1:0]),
      .ci    (r_carry),
      .s     (w_s),
      .co    (w_co),
      .c_msb (w_c_msb)
   );

   // Result chunks enter from the MSB side so after NCHUNK shifts chunk 0 sits at the LSB.
   if (NCHUNK == 1) begin : g_one
      assign w_sum_next = w_s;
   end else begin : g_many
      assign w_sum_next = {w_s, r_sum[WIDTH-1:CHUNK]};
   end

   assign w_last = (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_next = RUN;
         RUN:     if (w_last)   w_state_next = DONE;
         DONE:    if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= sub ? 1'b1 : cin;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_co;
               r_sum   <= w_sum_next;
               if (w_last) begin
                  r_cout <= w_co;
                  r_ovf  <= w_c_msb ^ w_co;
                  r_cnt  <= '0;
               end else begin
                  r_cnt  <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign sum       = r_sum;
   assign cout      = r_cout;
   assign overflow  = r_ovf;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder (WIDTH=16, CHUNK=4) with a result scoreboard.
module tb_chunked_serial_adder;

   localparam int W  = 16;
   localparam int EW = W + 2;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          overflow;
   logic [1:0]    dbg_state;

   logic [EW-1:0] exp_q[$];
   int            n_tests;
   int            n_fail;

   chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (actual timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard on each output handshake
   task automatic monitor_loop();
      logic [EW-1:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: actual sum=0x%0h with empty queue, required no output", sum);
            end else begin
               exp = exp_q.pop_front();
               check("result", {14'd0, overflow, cout, sum}, {14'd0, exp});
            end
         end
      end
   endtask

   // driver: issue one operation, push its expectation, measure accept->out_valid latency
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                       input logic tsub, input logic [W-1:0] esum, input logic ecout,
                       input logic eovf);
      int lat;
      int waitc;
      @(negedge clk);
      a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
      waitc = 0;
      while (!in_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      exp_q.push_back({eovf, ecout, esum});
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      check("latency", lat, 4);
   endtask

   task automatic wait_idle();
      int waitc;
      waitc = 0;
      while (!in_ready && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check("return_to_idle", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [W-1:0] held;
      int           seen_valid;
      n_tests = 0; n_fail = 0;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      rst_n = 1'b0;
      fork
         monitor_loop();
      join_none
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready",  {31'd0, in_ready},  32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_sum",       {16'd0, sum},       32'd0);
      check("reset_cout",      {31'd0, cout},      32'd0);
      check("reset_overflow",  {31'd0, overflow},  32'd0);
      rst_n = 1'b1;

      send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0); wait_idle();
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); wait_idle();
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); wait_idle();
      send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0); wait_idle();
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); wait_idle();
      send(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0); wait_idle();
      send(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0); wait_idle();

      // back-pressure in DONE while in_valid pulses
      @(negedge clk);
      out_ready = 1'b0;
      send(16'h1000, 16'h0234, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
      held = 16'h1235;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = i[0];
         a = 16'hFFFF; b = 16'hFFFF;
         @(posedge clk);
         #1;
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_in_ready",  {31'd0, in_ready},  32'd0);
         check("hold_sum",       {16'd0, sum},       {16'd0, held});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("after_release_in_ready",  {31'd0, in_ready},  32'd1);
      check("after_release_out_valid", {31'd0, out_valid}, 32'd0);

      // reset mid-RUN aborts the add
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_in_ready",  {31'd0, in_ready},  32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_sum",       {16'd0, sum},       32'd0);
      check("abort_cout",      {31'd0, cout},      32'd0);
      check("abort_overflow",  {31'd0, overflow},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 if (out_valid) seen_valid++;
      end
      check("abort_no_out_valid", seen_valid, 0);
      check("abort_idle_in_ready", {31'd0, in_ready}, 32'd1);

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
